// File: rtl/dive_pkg.sv
// Shared types and ASCII constants for the dive command parser.
package dive_pkg;

  typedef enum logic [1:0] {
    DIR_FWD  = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10,
    DIR_RST  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    S_WORD,
    S_SKIP,
    S_NUM,
    S_BAD
  } pstate_t;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;
  localparam logic [7:0] CH_LA = 8'h61;
  localparam logic [7:0] CH_LZ = 8'h7A;
  localparam logic [7:0] CH_F  = 8'h66;
  localparam logic [7:0] CH_U  = 8'h75;
  localparam logic [7:0] CH_D  = 8'h64;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

  function automatic logic is_lower(input logic [7:0] c);
    return (c >= CH_LA) && (c <= CH_LZ);
  endfunction

endpackage

// File: rtl/dive_dec_acc.sv
// Decimal accumulator: acc = acc*10 + digit, wrapping modulo 2^VALUE_W.
module dive_dec_acc #(
  parameter int VALUE_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               shift,
  input  logic [3:0]         digit,
  output logic [VALUE_W-1:0] acc
);

  // *10 as shift-and-add keeps this off a multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc <= '0;
    else if (clr)   acc <= '0;
    else if (shift) acc <= (acc << 3) + (acc << 1) + VALUE_W'(digit);
  end

endmodule

// File: rtl/dive_command_parser.sv
// ASCII "keyword N\n" line parser producing 1-cycle solver commands.
// Optional DIVE_PARSE_ERR_EN adds err_line / err_count for malformed lines.
module dive_command_parser
  import dive_pkg::*;
#(
  parameter int VALUE_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               enable,
  output logic [1:0]         direction,
  output logic [VALUE_W-1:0] value
`ifdef DIVE_PARSE_ERR_EN
  ,
  output logic               err_line,
  output logic [15:0]        err_count
`endif
);

  pstate_t            state, state_nx;
  dir_t               pend_dir, pend_dir_nx;
  logic               ndig, ndig_nx;
  logic               rdy_q, accept, is_lf;
  logic               emit, acc_clr, acc_shift;
  logic [VALUE_W-1:0] acc;

  // start steals the cycle: the byte on the bus is not taken.
  assign in_ready = rdy_q & ~start;
  assign accept   = in_valid & in_ready;
  assign is_lf    = (in_data == CH_LF);

  dive_dec_acc #(.VALUE_W(VALUE_W)) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .shift (acc_shift),
    .digit (in_data[3:0]),
    .acc   (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WORD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    pend_dir_nx = pend_dir;
    ndig_nx     = ndig;
    emit        = 1'b0;
    acc_clr     = start;
    acc_shift   = 1'b0;
    if (start) begin
      state_nx = S_WORD;
      ndig_nx  = 1'b0;
    end else if (accept && (in_data != CH_CR)) begin
      case (state)
        S_WORD: begin
          if (in_data == CH_F || in_data == CH_U || in_data == CH_D) begin
            if (in_data == CH_F)      pend_dir_nx = DIR_FWD;
            else if (in_data == CH_U) pend_dir_nx = DIR_UP;
            else                      pend_dir_nx = DIR_DOWN;
            acc_clr  = 1'b1;
            ndig_nx  = 1'b0;
            state_nx = S_SKIP;
          end else if (!is_lf) begin
            state_nx = S_BAD;
          end
        end
        S_SKIP: begin
          if (is_lf)                   state_nx = S_WORD;
          else if (in_data == CH_SP)   state_nx = S_NUM;
          else if (!is_lower(in_data)) state_nx = S_BAD;
        end
        S_NUM: begin
          if (is_digit(in_data)) begin
            acc_shift = 1'b1;
            ndig_nx   = 1'b1;
          end else if (is_lf) begin
            emit     = ndig;
            state_nx = S_WORD;
          end else if (!(in_data == CH_SP && !ndig)) begin
            state_nx = S_BAD;
          end
        end
        S_BAD:   if (is_lf) state_nx = S_WORD;
        default: state_nx = S_WORD;
      endcase
    end
  end

  // direction/value hold the last command between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q     <= 1'b0;
      pend_dir  <= DIR_FWD;
      ndig      <= 1'b0;
      enable    <= 1'b0;
      direction <= 2'b00;
      value     <= '0;
    end else begin
      rdy_q    <= 1'b1;
      pend_dir <= pend_dir_nx;
      ndig     <= ndig_nx;
      enable   <= start | emit;
      if (start) begin
        direction <= DIR_RST;
        value     <= '0;
      end else if (emit) begin
        direction <= pend_dir;
        value     <= acc;
      end
    end
  end

`ifdef DIVE_PARSE_ERR_EN
  logic line_err;

  // A line is malformed if it ends while discarding, mid-keyword, or with no digits.
  assign line_err = accept && is_lf &&
                    (state == S_BAD || state == S_SKIP || (state == S_NUM && !ndig));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_line  <= 1'b0;
      err_count <= '0;
    end else begin
      err_line <= line_err;
      if (start)                                  err_count <= '0;
      else if (line_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dive_command_parser.sv
// Directed bench for dive_command_parser: table of lines plus start/reset corner sequences.
module tb_dive_command_parser;

  localparam int VW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, enable;
  logic [1:0]    direction;
  logic [VW-1:0] value;
`ifdef DIVE_PARSE_ERR_EN
  logic          err_line;
  logic [15:0]   err_count;
  int            err_seen = 0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [33:0] strobes[$];

  typedef struct {
    string       txt;
    int          n;
    logic [1:0]  d0;
    logic [31:0] v0;
    logic [1:0]  d1;
    logic [31:0] v1;
    int          errs;
  } vec_t;

  vec_t tv[8];

  always #5 clk = ~clk;

  dive_command_parser #(.VALUE_W(VW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .enable    (enable),
    .direction (direction),
    .value     (value)
`ifdef DIVE_PARSE_ERR_EN
    ,
    .err_line  (err_line),
    .err_count (err_count)
`endif
  );

  always @(negedge clk) if (rst_n && enable) strobes.push_back({direction, value});
`ifdef DIVE_PARSE_ERR_EN
  always @(negedge clk) if (rst_n && err_line) err_seen++;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int k = 0; k < s.len(); k++) send_byte(s[k]);
  endtask

  initial begin
    int err_total;
    err_total = 0;
    tv[0] = '{"forward 5\n",                        1, 2'd0, 32'd5,          2'd0, 32'd0, 0};
    tv[1] = '{"up 3\r\ndown 8\n\n",                 2, 2'd1, 32'd3,          2'd2, 32'd8, 0};
    tv[2] = '{"sideways 4\nforward 12\n",           1, 2'd0, 32'd12,         2'd0, 32'd0, 1};
    tv[3] = '{"down 4294967296\n",                  1, 2'd2, 32'd0,          2'd0, 32'd0, 0};
    tv[4] = '{"down 4294967295\n",                  1, 2'd2, 32'hFFFF_FFFF,  2'd0, 32'd0, 0};
    tv[5] = '{"up 2\ndown\nforward \nup x\n",       1, 2'd1, 32'd2,          2'd0, 32'd0, 3};
    tv[6] = '{"\n forward 7\nup  10\n",             1, 2'd1, 32'd10,         2'd0, 32'd0, 1};
    tv[7] = '{"down 12 \nforward 0\n",              1, 2'd0, 32'd0,          2'd0, 32'd0, 1};

    // Reset state
    #12;
    check("rst_enable", {63'd0, enable}, 64'd0);
    check("rst_dir", {62'd0, direction}, 64'd0);
    check("rst_value", {32'd0, value}, 64'd0);
    check("rst_ready", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("ready_before_clk", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    check("ready_after_clk", {63'd0, in_ready}, 64'd1);

    // Table-driven lines
    for (int i = 0; i < 8; i++) begin
`ifdef DIVE_PARSE_ERR_EN
      int e0;
      e0 = err_seen;
`endif
      strobes.delete();
      send_str(tv[i].txt);
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("vec%0d_count", i), 64'(strobes.size()), 64'(tv[i].n));
      if (strobes.size() > 0)
        check($sformatf("vec%0d_cmd0", i), {30'd0, strobes[0]}, {30'd0, tv[i].d0, tv[i].v0});
      if (tv[i].n > 1 && strobes.size() > 1)
        check($sformatf("vec%0d_cmd1", i), {30'd0, strobes[1]}, {30'd0, tv[i].d1, tv[i].v1});
`ifdef DIVE_PARSE_ERR_EN
      err_total += tv[i].errs;
      check($sformatf("vec%0d_err_pulses", i), 64'(err_seen - e0), 64'(tv[i].errs));
      check($sformatf("vec%0d_err_count", i), {48'd0, err_count}, 64'(err_total));
`endif
    end

    // Exact strobe latency and hold
    send_str("forward 5");
    check("lat_pre_lf", {63'd0, enable}, 64'd0);
    send_byte(8'h0A);
    check("lat_strobe", {63'd0, enable}, 64'd1);
    check("lat_cmd", {30'd0, direction, value}, {30'd0, 2'd0, 32'd5});
    @(posedge clk);
    #1;
    check("lat_drop", {63'd0, enable}, 64'd0);
    check("lat_hold", {30'd0, direction, value}, {30'd0, 2'd0, 32'd5});

    // start colliding with the terminating newline
    strobes.delete();
    send_str("up 7");
    in_valid = 1'b1;
    in_data  = 8'h0A;
    start    = 1'b1;
    #1;
    check("start_ready_low", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    check("start_strobe", {63'd0, enable}, 64'd1);
    check("start_cmd", {30'd0, direction, value}, {30'd0, 2'd3, 32'd0});
`ifdef DIVE_PARSE_ERR_EN
    check("start_err_clr", {48'd0, err_count}, 64'd0);
`endif
    send_str("down 6\n");
    @(posedge clk);
    #1;
    check("start_seq_count", 64'(strobes.size()), 64'd2);
    if (strobes.size() > 1) begin
      check("start_seq_0", {30'd0, strobes[0]}, {30'd0, 2'd3, 32'd0});
      check("start_seq_1", {30'd0, strobes[1]}, {30'd0, 2'd2, 32'd6});
    end

    // Back-to-back start pulses
    start = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_first", {61'd0, enable, direction}, {61'd0, 1'b1, 2'd3});
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_second", {61'd0, enable, direction}, {61'd0, 1'b1, 2'd3});
    @(posedge clk);
    #1;
    check("b2b_end", {63'd0, enable}, 64'd0);

    // Async reset in the middle of a line
    send_str("up 11\n");
    send_str("forward 9");
    #2;
    rst_n = 1'b0;
    #1;
    check("amid_rst_out", {30'd0, enable, in_ready, direction, value}, 64'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    strobes.delete();
    send_str("\nup 2\n");
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_count", 64'(strobes.size()), 64'd1);
    if (strobes.size() > 0)
      check("post_rst_cmd", {30'd0, strobes[0]}, {30'd0, 2'd1, 32'd2});
`ifdef DIVE_PARSE_ERR_EN
    check("post_rst_err", {48'd0, err_count}, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
